// File: rtl/mem_burst_sequencer_pkg.sv
// ------------------------------------------------------------------
// mem_seq_pkg : shared types, default widths and address helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_seq_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_RSP_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  // Increment wrapping modulo 2^width (width up to 32).
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr + 32'd1) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_burst_sequencer_rsp_fifo.sv
// ------------------------------------------------------------------
// seq_rsp_fifo : synchronous FIFO with occupancy count
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seq_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot that the push reuses.
  assign w_do_push = push && (!w_full || w_do_pop);
  assign pop_data  = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_burst_sequencer.sv
// ------------------------------------------------------------------
// mem_burst_sequencer : burst read/write master for the memory stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_burst_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beats_left;
  logic [RD_LAT:0]   r_vpipe;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_can_issue;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_last;
  logic              w_pipe_empty;

  assign w_pipe_empty = (r_vpipe == '0);
  // Every read in the pipe already owns a FIFO slot, so a push can never overflow.
  assign w_can_issue  = (int'(w_fifo_count) + $countones(r_vpipe) + 1) <= RSP_DEPTH;
  assign w_wr_fire    = (r_state == WR_BURST) && wr_valid && w_pipe_empty;
  assign w_rd_fire    = (r_state == RD_BURST) && w_can_issue;
  assign w_last       = (r_beats_left == '0);

  assign cmd_ready = !reset && (r_state == IDLE);
  // Writes wait for outstanding reads so the memory sees them in command order.
  assign wr_ready  = (r_state == WR_BURST) && w_pipe_empty;
  assign busy      = (r_state != IDLE) || !w_pipe_empty;
  assign rsp_valid = !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_vpipe      <= '0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_vpipe[0] <= w_rd_fire;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end

      case (r_state)
        IDLE: begin
          mem_rw <= 1'b0;
          if (cmd_valid) begin
            r_addr       <= cmd_addr;
            r_beats_left <= cmd_len;
            r_state      <= cmd_write ? WR_BURST : RD_BURST;
          end
        end

        WR_BURST: begin
          if (w_wr_fire) begin
            mem_rw       <= 1'b1;
            mem_addr     <= r_addr;
            mem_wdata    <= wr_data;
            r_addr       <= ADDR_W'(next_addr(32'(r_addr), ADDR_W));
            r_beats_left <= r_beats_left - LEN_W'(1);
            if (w_last) r_state <= IDLE;
          end else begin
            mem_rw <= 1'b0;
          end
        end

        RD_BURST: begin
          mem_rw <= 1'b0;
          if (w_rd_fire) begin
            mem_addr     <= r_addr;
            r_addr       <= ADDR_W'(next_addr(32'(r_addr), ADDR_W));
            r_beats_left <= r_beats_left - LEN_W'(1);
            if (w_last) r_state <= IDLE;
          end
        end

        default: begin
          mem_rw  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  seq_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (r_vpipe[RD_LAT]),
    .push_data (mem_rdata),
    .pop       (rsp_ready),
    .pop_data  (rsp_data),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_sequencer.sv
// ------------------------------------------------------------------
// tb_mem_burst_sequencer : directed bench with a 256x8 memory model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_burst_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       mem_rw;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_model [256];
  logic       init_mem;
  logic [7:0] rsp_q [$];

  always #5 clk = ~clk;

  mem_burst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory stage: write on mem_rw, registered read one cycle later.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 8'(i) ^ 8'h5A;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_rw) mem_model[mem_addr] <= mem_wdata;
      mem_rdata <= mem_model[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (!reset && rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
  end

  always @(negedge clk) begin
    if (!reset && dut.u_rsp_fifo.push && dut.u_rsp_fifo.w_full && !dut.u_rsp_fifo.pop) begin
      errors++;
      $display("FAIL fifo_overflow: push while full without pop at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len);
    logic accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        @(posedge clk);
        @(negedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("cmd_accept_timeout", accepted, 1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (!busy && !rsp_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic chk_q(input string name, input int idx, input logic [7:0] exp);
    chk(name, (idx < rsp_q.size()) ? {24'd0, rsp_q[idx]} : 32'hDEAD_BEEF, {24'd0, exp});
  endtask

  typedef struct {
    logic       cv;
    logic       cw;
    logic [7:0] ca;
    logic [3:0] cl;
    logic       wv;
    logic [7:0] wd;
    logic       e_rw;
    logic [7:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_crdy;
    logic       e_wrdy;
    logic       e_busy;
  } vec_t;

  vec_t vecs [14];

  logic       seen_wr;
  logic       prev_rv;
  logic [7:0] exp_fe [6];

  initial begin
    // Write burst at 0x10 (data every cycle), then a stalled burst at 0x20.
    vecs[0]  = '{1'b1, 1'b1, 8'h10, 4'd3, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hA0, 1'b1, 8'h10, 8'hA0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hA1, 1'b1, 8'h11, 8'hA1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hA2, 1'b1, 8'h12, 8'hA2, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hA3, 1'b1, 8'h13, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h77, 1'b0, 8'h13, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h20, 4'd3, 1'b0, 8'h00, 1'b0, 8'h13, 8'hA3, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hB0, 1'b1, 8'h20, 8'hB0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h55, 1'b0, 8'h20, 8'hB0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h55, 1'b0, 8'h20, 8'hB0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hB1, 1'b1, 8'h21, 8'hB1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hB2, 1'b1, 8'h22, 8'hB2, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h55, 1'b0, 8'h22, 8'hB2, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'hB3, 1'b1, 8'h23, 8'hB3, 1'b1, 1'b0, 1'b0};

    // Preloaded contents (addr ^ 0x5A) at FE, FF, 00, 01, 02, 03.
    exp_fe[0] = 8'hA4; exp_fe[1] = 8'hA5; exp_fe[2] = 8'h5A;
    exp_fe[3] = 8'h5B; exp_fe[4] = 8'h58; exp_fe[5] = 8'h59;

    reset = 1'b1; init_mem = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 4'd0;
    wr_valid = 1'b0; wr_data = 8'h00; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("cmd_ready_in_reset", cmd_ready, 1'b0);
    reset = 1'b0; init_mem = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rw", mem_rw, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
      cmd_addr  = vecs[i].ca; cmd_len   = vecs[i].cl;
      wr_valid  = vecs[i].wv; wr_data   = vecs[i].wd;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_rw", i),    mem_rw,    vecs[i].e_rw);
      chk($sformatf("vec%0d_mem_addr", i),  mem_addr,  vecs[i].e_addr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].e_crdy);
      chk($sformatf("vec%0d_wr_ready", i),  wr_ready,  vecs[i].e_wrdy);
      chk($sformatf("vec%0d_busy", i),      busy,      vecs[i].e_busy);
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;

    // Read back 0x10..0x13 with the consumer always ready.
    rsp_q.delete();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 8'h10, 4'd3);
    @(negedge clk);
    chk("rd_first_issue_addr", mem_addr, 8'h10);
    chk("rd_first_issue_rw", mem_rw, 1'b0);
    chk("rd_rsp_not_yet_1", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_rsp_not_yet_2", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rd_first_rsp_valid", rsp_valid, 1'b1);
    chk("rd_first_rsp_data", rsp_data, 8'hA0);
    wait_drain(40);
    chk("rd_rsp_count", rsp_q.size(), 4);
    chk_q("rd_rsp0", 0, 8'hA0);
    chk_q("rd_rsp1", 1, 8'hA1);
    chk_q("rd_rsp2", 2, 8'hA2);
    chk_q("rd_rsp3", 3, 8'hA3);

    // Wrapping read with the consumer stalled: credits cap issue at four beats.
    rsp_q.delete();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 8'hFE, 4'd5);
    repeat (10) @(negedge clk);
    chk("bp_last_issue_addr", mem_addr, 8'h01);
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_head", rsp_data, 8'hA4);
    chk("bp_busy", busy, 1'b1);
    chk("bp_fifo_count", dut.u_rsp_fifo.count, 3'd4);
    repeat (3) @(negedge clk);
    chk("bp_still_stalled", mem_addr, 8'h01);
    rsp_ready = 1'b1;
    wait_drain(60);
    chk("bp_rsp_count", rsp_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_q($sformatf("bp_rsp%0d", i), i, exp_fe[i]);

    // Reset lands on the second beat of a long read.
    rsp_q.delete();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 8'h30, 4'd7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_mem_rw", mem_rw, 1'b0);
    chk("mid_rst_cmd_ready_held", cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_stale_rsp", rsp_q.size(), 0);
    chk("mid_rst_rsp_valid_late", rsp_valid, 1'b0);
    chk("mid_rst_busy_late", busy, 1'b0);

    // Single-beat read followed at once by a write: read data lands first.
    rsp_q.delete();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 8'h40, 4'd0);
    wr_valid = 1'b1;
    wr_data  = 8'hC5;
    send_cmd(1'b1, 8'h50, 4'd0);
    seen_wr = 1'b0;
    prev_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_rw) begin
        seen_wr = 1'b1;
        break;
      end
      prev_rv = rsp_valid;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("rw_order_write_seen", seen_wr, 1'b1);
    chk("rw_order_read_pushed_first", prev_rv, 1'b1);
    chk("rw_order_wr_addr", mem_addr, 8'h50);
    chk("rw_order_wr_data", mem_wdata, 8'hC5);
    chk("rw_order_rsp_data", rsp_data, 8'h1A);
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_drain(40);
    chk("rw_order_rsp_count", rsp_q.size(), 1);
    chk_q("rw_order_rsp0", 0, 8'h1A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_burst_sequencer.md
Name: mem_burst_sequencer

Overview:
- Upstream master for the 256x8 single-port memory stage. Accepts burst read/write commands over a valid/ready handshake.
- Drives the memory's rw/address/data pins one beat per cycle, with the address incrementing and wrapping modulo 256.
- Returns read data through a credit-protected response FIFO with backpressure.
- Sits between the register/test-bench agent and the memory stage.

Parameters:
- ADDR_W, 8, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory data width.
- LEN_W, 4, burst length field width; beats = cmd_len+1 (1..16).
- RD_LAT, 1, cycles from read issue to valid mem_rdata.
- RSP_DEPTH, 4, response FIFO entries (power of 2, >= RD_LAT+1).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write beat data offered.
- wr_ready  out  1  write beat consumed.
- wr_data  in  DATA_W  write beat data.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  read response data.
- mem_rw  out  1  to memory: 1=write, 0=read.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_rdata  in  DATA_W  from memory read data.
- busy  out  1  high while not IDLE or reads in flight.

Behaviour:
- Reset (reset=1 at clk edge): state=IDLE, mem_rw=0, mem_addr=0, mem_wdata=0, wr_ready=0, rsp_valid=0, FIFO emptied, in-flight pipe cleared, busy=0. cmd_ready=0 while reset is high.
- Reset mid-burst aborts immediately. Remaining beats are dropped and in-flight read data is discarded.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr and beats_left=cmd_len.
  - Go to WR_BURST if cmd_write, else RD_BURST.
  - mem_rw=0 while idle.
- WR_BURST:
  - wr_ready=1.
  - Each cycle with wr_valid: register mem_rw=1, mem_addr=addr, mem_wdata=wr_data for the next cycle.
  - Then addr<=addr+1 (wrap 255->0) and beats_left decrements.
  - A cycle without wr_valid is a stall: mem_rw=0, and addr/count hold.
  - After the final beat, return to IDLE. cmd_ready rises the cycle after the last beat is registered.
- RD_BURST:
  - Issue a read beat (mem_rw=0, mem_addr=addr) only when fifo_count + inflight + 1 <= RSP_DEPTH. Otherwise stall without advancing.
  - Each issued beat enters a RD_LAT-deep valid pipe. When it emerges, mem_rdata is pushed into the FIFO.
  - After the final issue, return to IDLE. Outstanding reads still complete and busy stays high until the pipe drains.
  - A new command may be accepted while reads drain.
- Ordering: read responses are in issue order. A write command accepted after a read burst may not issue until the in-flight pipe is empty (read-before-write ordering at the memory).
- Response FIFO:
  - rsp_valid = !empty; rsp_data = head.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both allowed, including when full (credit check guarantees no overflow).
  - Overflow is unreachable. The bench asserts it never occurs.
- Address wrap: cmd_addr=8'hFE, cmd_len=3 issues FE, FF, 00, 01.
- cmd_len=0 yields exactly one beat.
- mem_addr holds its last value when idle.

Decomposition:
- Package mem_seq_pkg:
  - state_t enum {IDLE, WR_BURST, RD_BURST}.
  - Default-width localparams.
  - Function next_addr(addr) wrapping modulo 2^ADDR_W.
- Sub-module: seq_rsp_fifo. Synchronous FIFO (DEPTH, WIDTH) with count output, used for the response path.
- Top holds the FSM, the address/beat counters, the credit logic and the RD_LAT valid shift register.

Test Plan:
- Write burst addr=8'h10, len=3, data A0..A3 with wr_valid always high -> mem_rw=1 for 4 consecutive cycles at addresses 10..13 with data A0..A3; cmd_ready returns next cycle.
- Read burst addr=8'h10, len=3, rsp_ready=1, memory model preloaded -> rsp_data sequence A0..A3, first rsp_valid RD_LAT+1 cycles after the first issue.
- Read burst addr=8'hFE, len=5, rsp_ready=0 -> exactly RSP_DEPTH (4) reads issued (FE, FF, 00, 01), then stall. Raising rsp_ready completes beats 02, 03 in order.
- Write burst with wr_valid toggling 1,0,0,1 -> beats are issued only on valid cycles, address is not skipped, and mem_rw=0 during stalls.
- Reset asserted on the 2nd beat of a len=7 read -> next cycle: rsp_valid=0, busy=0, mem_rw=0, cmd_ready=1 after reset deasserts; no stale responses appear.
- Read len=0 immediately followed by a write command -> the write's first mem_rw=1 occurs only after the read data is pushed into the FIFO.
